// File: rtl/uart_tx_arbiter_if.sv
// Requester-to-UART byte bus shared by the arbiter and its environment.
// The slave modport is the arbiter. The master modport is the requesters
// together with the UART transmit FIFO.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_last;
  logic [NUM_REQ-1:0]   req_ready;
  logic [7:0]           tx_data;
  logic                 tx_we;
  logic                 tx_full;

  modport slave (
    input  req_valid, req_data, req_last, tx_full,
    output req_ready, tx_data, tx_we
  );

  modport master (
    output req_valid, req_data, req_last, tx_full,
    input  req_ready, tx_data, tx_we
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin packet arbiter that feeds N byte requesters into one UART TX FIFO.
// A grant is held for a whole packet. The packet ends on req_last, or it is
// cut short when the granted requester stays idle for too long.

// Per-channel handshake. The data output is zero unless this lane transfers,
// so the top level can OR all lanes together to form tx_data.
module uart_tx_arbiter_lane (
  input  logic       locked,
  input  logic       gnt,
  input  logic       tx_full,
  input  logic       valid,
  input  logic [7:0] data,
  output logic       ready,
  output logic       xfer,
  output logic [7:0] data_o
);
  assign ready  = locked & gnt & ~tx_full;
  assign xfer   = ready & valid;
  assign data_o = xfer ? data : 8'h00;
endmodule

module uart_tx_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  uart_tx_arbiter_if.slave    bus,
  output logic [NUM_REQ-1:0]  grant,
  output logic                busy,
  output logic                timeout_event,
  output logic [15:0]         byte_count
);
  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_LOCKED = 1'b1;
  localparam int LW = $clog2(NUM_REQ);
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  logic [0:0]         state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [LW-1:0]      cur_q, cur_d;
  logic [LW-1:0]      last_q, last_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [15:0]        bc_q, bc_d;

  logic                     locked;
  logic [NUM_REQ-1:0]       lane_ready;
  logic [NUM_REQ-1:0]       lane_xfer;
  logic [NUM_REQ-1:0][7:0]  lane_data;
  logic [7:0]               txd;
  logic                     xfer;
  logic                     cur_valid;
  logic                     cur_last;
  logic                     to_hit;
  logic [LW-1:0]            pick;
  logic                     pick_ok;

  assign locked = (state_q == S_LOCKED);

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
    uart_tx_arbiter_lane u_lane (
      .locked  (locked),
      .gnt     (grant_q[i]),
      .tx_full (bus.tx_full),
      .valid   (bus.req_valid[i]),
      .data    (bus.req_data[8*i +: 8]),
      .ready   (lane_ready[i]),
      .xfer    (lane_xfer[i]),
      .data_o  (lane_data[i])
    );
  end

  // Merge the lanes. At most one lane can transfer, so an OR of the lanes acts as the mux.
  always_comb begin
    txd = 8'h00;
    for (int i = 0; i < NUM_REQ; i++) txd = txd | lane_data[i];
  end

  assign xfer          = |lane_xfer;
  assign bus.req_ready = lane_ready;
  assign bus.tx_we     = xfer;
  assign bus.tx_data   = txd;

  assign cur_valid = bus.req_valid[cur_q];
  assign cur_last  = bus.req_last[cur_q];

  // The idle cycle that would bring the counter up to TIMEOUT. A transfer
  // needs valid, so a transfer and this condition can never happen in the
  // same cycle.
  assign to_hit = (TIMEOUT > 0) && locked && !cur_valid &&
                  (cnt_q == CW'(TIMEOUT - 1));

  // Round-robin search. The loop walks from the farthest candidate to the nearest.
  // The nearest valid channel after last_q is therefore the last one written and wins.
  always_comb begin
    pick    = '0;
    pick_ok = 1'b0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      logic [LW-1:0] idx;
      idx = LW'((int'(last_q) + k) % NUM_REQ);
      if (bus.req_valid[idx]) begin
        pick    = idx;
        pick_ok = 1'b1;
      end
    end
  end

  // FSM: grant in IDLE, hold the grant for the packet in LOCKED, release it on last or timeout.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    cur_d   = cur_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    bc_d    = bc_q + {15'd0, xfer};
    case (state_q)
      S_IDLE: begin
        if (enable && pick_ok) begin
          state_d = S_LOCKED;
          cur_d   = pick;
          grant_d = NUM_REQ'(1) << pick;
          cnt_d   = '0;
        end
      end
      S_LOCKED: begin
        if (xfer) begin
          cnt_d = '0;
          if (cur_last) begin
            state_d = S_IDLE;
            grant_d = '0;
            last_d  = cur_q;
          end
        end else if (to_hit) begin
          state_d = S_IDLE;
          grant_d = '0;
          last_d  = cur_q;
          cnt_d   = '0;
        end else if (!cur_valid && (TIMEOUT > 0)) begin
          // A tx_full stall with valid high does not reach this branch, so it does not count.
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        grant_d = '0;
      end
    endcase
  end

  // State registers. The asynchronous reset aborts any packet in progress.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      cur_q   <= '0;
      last_q  <= LW'(NUM_REQ - 1);
      cnt_q   <= '0;
      bc_q    <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      cur_q   <= cur_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      bc_q    <= bc_d;
    end
  end

  assign grant         = grant_q;
  assign busy          = locked;
  assign timeout_event = to_hit;
  assign byte_count    = bc_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter (4 channels, TIMEOUT = 4).
module tb_uart_tx_arbiter;
  localparam int N = 4;
  localparam logic [31:0] D0 = 32'h44332211;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic enable = 1'b0;
  logic [N-1:0] grant;
  logic busy, tev;
  logic [15:0] bc;
  int n_cmp = 0;
  int n_bad = 0;

  uart_tx_arbiter_if #(.NUM_REQ(N)) bus ();

  uart_tx_arbiter #(.NUM_REQ(N), .TIMEOUT(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .enable        (enable),
    .bus           (bus.slave),
    .grant         (grant),
    .busy          (busy),
    .timeout_event (tev),
    .byte_count    (bc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic [3:0]  v;
    logic [3:0]  l;
    logic [31:0] d;
    logic        full;
    logic [3:0]  g;
    logic [3:0]  rdy;
    logic        we;
    logic [7:0]  txd;
    logic        bsy;
    logic        tev;
    logic [15:0] bc;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic en, logic [3:0] v, logic [3:0] l, logic [31:0] d,
                              logic full, logic [3:0] g, logic [3:0] rdy, logic we,
                              logic [7:0] txd, logic bsy, logic t, logic [15:0] b);
    vec_t r;
    r.en = en; r.v = v; r.l = l; r.d = d; r.full = full;
    r.g = g; r.rdy = rdy; r.we = we; r.txd = txd; r.bsy = bsy; r.tev = t; r.bc = b;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input logic [3:0] g, input logic [3:0] rdy,
                         input logic we, input logic [7:0] txd, input logic bsy,
                         input logic t, input logic [15:0] b);
    chk({tag, " grant"},      32'(grant),         32'(g));
    chk({tag, " req_ready"},  32'(bus.req_ready), 32'(rdy));
    chk({tag, " tx_we"},      32'(bus.tx_we),     32'(we));
    chk({tag, " tx_data"},    32'(bus.tx_data),   32'(txd));
    chk({tag, " busy"},       32'(busy),          32'(bsy));
    chk({tag, " timeout_ev"}, 32'(tev),           32'(t));
    chk({tag, " byte_count"}, 32'(bc),            32'(b));
  endtask

  // Apply inputs just after the falling edge, then settle briefly before checking.
  task automatic drive(input logic en, input logic [3:0] v, input logic [3:0] l,
                       input logic [31:0] d, input logic full);
    @(negedge clk);
    enable        = en;
    bus.req_valid = v;
    bus.req_last  = l;
    bus.req_data  = d;
    bus.tx_full   = full;
    #1;
  endtask

  initial begin
    // Rows 0-6: single-byte packets on channels 1 and 3. Rows 7-13: a three-byte
    // packet on channel 0 while channel 1 waits. Rows 14-15: enable low.
    tbl.push_back(mk(1, 4'b1010, 4'b1010, D0,           0, 4'b0000, 4'b0000, 0, 8'h00, 0, 0, 16'd0));
    tbl.push_back(mk(1, 4'b1010, 4'b1010, D0,           0, 4'b0010, 4'b0010, 1, 8'h22, 1, 0, 16'd0));
    tbl.push_back(mk(1, 4'b1010, 4'b1010, D0,           0, 4'b0000, 4'b0000, 0, 8'h00, 0, 0, 16'd1));
    tbl.push_back(mk(1, 4'b1010, 4'b1010, D0,           0, 4'b1000, 4'b1000, 1, 8'h44, 1, 0, 16'd1));
    tbl.push_back(mk(1, 4'b1010, 4'b1010, D0,           0, 4'b0000, 4'b0000, 0, 8'h00, 0, 0, 16'd2));
    tbl.push_back(mk(1, 4'b1010, 4'b1010, D0,           0, 4'b0010, 4'b0010, 1, 8'h22, 1, 0, 16'd2));
    tbl.push_back(mk(1, 4'b0000, 4'b1010, D0,           0, 4'b0000, 4'b0000, 0, 8'h00, 0, 0, 16'd3));
    tbl.push_back(mk(1, 4'b0011, 4'b0010, 32'h44332241, 0, 4'b0000, 4'b0000, 0, 8'h00, 0, 0, 16'd3));
    tbl.push_back(mk(1, 4'b0011, 4'b0010, 32'h44332241, 0, 4'b0001, 4'b0001, 1, 8'h41, 1, 0, 16'd3));
    tbl.push_back(mk(1, 4'b0011, 4'b0010, 32'h44332242, 0, 4'b0001, 4'b0001, 1, 8'h42, 1, 0, 16'd4));
    tbl.push_back(mk(1, 4'b0011, 4'b0011, 32'h44332243, 0, 4'b0001, 4'b0001, 1, 8'h43, 1, 0, 16'd5));
    tbl.push_back(mk(1, 4'b0010, 4'b0010, D0,           0, 4'b0000, 4'b0000, 0, 8'h00, 0, 0, 16'd6));
    tbl.push_back(mk(1, 4'b0010, 4'b0010, D0,           0, 4'b0010, 4'b0010, 1, 8'h22, 1, 0, 16'd6));
    tbl.push_back(mk(1, 4'b0000, 4'b0000, D0,           0, 4'b0000, 4'b0000, 0, 8'h00, 0, 0, 16'd7));
    tbl.push_back(mk(0, 4'b1111, 4'b1111, D0,           0, 4'b0000, 4'b0000, 0, 8'h00, 0, 0, 16'd7));
    tbl.push_back(mk(0, 4'b1111, 4'b1111, D0,           0, 4'b0000, 4'b0000, 0, 8'h00, 0, 0, 16'd7));

    // Outputs must stay quiet while reset is held, even with every request asserted.
    enable = 1'b1; bus.req_valid = 4'b1111; bus.req_last = 4'b1111;
    bus.req_data = D0; bus.tx_full = 1'b0;
    repeat (2) @(negedge clk);
    #1 chk_all("reset", 4'b0000, 4'b0000, 0, 8'h00, 0, 0, 16'd0);
    @(negedge clk);
    enable = 1'b0; bus.req_valid = 4'b0000;
    rst = 1'b1;

    foreach (tbl[i]) begin
      drive(tbl[i].en, tbl[i].v, tbl[i].l, tbl[i].d, tbl[i].full);
      chk_all($sformatf("row%0d", i), tbl[i].g, tbl[i].rdy, tbl[i].we, tbl[i].txd,
              tbl[i].bsy, tbl[i].tev, tbl[i].bc);
    end

    // tx_full stall mid-packet on channel 2: long enough to trip the timeout if it counted.
    drive(1, 4'b0100, 4'b0000, D0, 0); chk_all("full_idle", 4'b0000, 4'b0000, 0, 8'h00, 0, 0, 16'd7);
    drive(1, 4'b0100, 4'b0000, D0, 0); chk_all("full_b0",   4'b0100, 4'b0100, 1, 8'h33, 1, 0, 16'd7);
    for (int i = 0; i < 10; i++) begin
      drive(1, 4'b0100, 4'b0000, D0, 1);
      chk_all($sformatf("full_stall%0d", i), 4'b0100, 4'b0000, 0, 8'h00, 1, 0, 16'd8);
    end
    drive(1, 4'b0100, 4'b0100, D0, 0); chk_all("full_resume", 4'b0100, 4'b0100, 1, 8'h33, 1, 0, 16'd8);
    drive(1, 4'b0000, 4'b0000, D0, 0); chk_all("full_done",   4'b0000, 4'b0000, 0, 8'h00, 0, 0, 16'd9);

    // Timeout on channel 3. A transfer after 3 idle cycles clears the count;
    // 4 further idle cycles then fire the timeout.
    drive(1, 4'b1000, 4'b0000, D0, 0); chk_all("to_req", 4'b0000, 4'b0000, 0, 8'h00, 0, 0, 16'd9);
    drive(1, 4'b1000, 4'b0000, D0, 0); chk_all("to_b0",  4'b1000, 4'b1000, 1, 8'h44, 1, 0, 16'd9);
    for (int i = 0; i < 3; i++) begin
      drive(1, 4'b0010, 4'b0000, D0, 0);
      chk_all($sformatf("to_gapA%0d", i), 4'b1000, 4'b1000, 0, 8'h00, 1, 0, 16'd10);
    end
    drive(1, 4'b1010, 4'b0000, D0, 0); chk_all("to_b1", 4'b1000, 4'b1000, 1, 8'h44, 1, 0, 16'd10);
    for (int i = 0; i < 3; i++) begin
      drive(1, 4'b0010, 4'b0000, D0, 0);
      chk_all($sformatf("to_gapB%0d", i), 4'b1000, 4'b1000, 0, 8'h00, 1, 0, 16'd11);
    end
    drive(1, 4'b0010, 4'b0010, D0, 0); chk_all("to_fire",  4'b1000, 4'b1000, 0, 8'h00, 1, 1, 16'd11);
    drive(1, 4'b0010, 4'b0010, D0, 0); chk_all("to_clear", 4'b0000, 4'b0000, 0, 8'h00, 0, 0, 16'd11);
    drive(1, 4'b0010, 4'b0010, D0, 0); chk_all("to_next",  4'b0010, 4'b0010, 1, 8'h22, 1, 0, 16'd11);
    drive(1, 4'b0000, 4'b0000, D0, 0); chk_all("to_done",  4'b0000, 4'b0000, 0, 8'h00, 0, 0, 16'd12);

    // Dropping enable mid-packet lets channel 0 finish, and no new grant follows.
    drive(1, 4'b0001, 4'b0000, D0, 0); chk_all("en_req",  4'b0000, 4'b0000, 0, 8'h00, 0, 0, 16'd12);
    drive(0, 4'b0001, 4'b0000, D0, 0); chk_all("en_b0",   4'b0001, 4'b0001, 1, 8'h11, 1, 0, 16'd12);
    drive(0, 4'b0001, 4'b0001, D0, 0); chk_all("en_b1",   4'b0001, 4'b0001, 1, 8'h11, 1, 0, 16'd13);
    drive(0, 4'b1111, 4'b1111, D0, 0); chk_all("en_off0", 4'b0000, 4'b0000, 0, 8'h00, 0, 0, 16'd14);
    drive(0, 4'b1111, 4'b1111, D0, 0); chk_all("en_off1", 4'b0000, 4'b0000, 0, 8'h00, 0, 0, 16'd14);

    // Asynchronous reset in the middle of a channel 2 packet.
    drive(1, 4'b0100, 4'b0000, D0, 0); chk_all("rs_req", 4'b0000, 4'b0000, 0, 8'h00, 0, 0, 16'd14);
    drive(1, 4'b0100, 4'b0000, D0, 0); chk_all("rs_b0",  4'b0100, 4'b0100, 1, 8'h33, 1, 0, 16'd14);
    drive(1, 4'b0100, 4'b0000, D0, 0); chk_all("rs_b1",  4'b0100, 4'b0100, 1, 8'h33, 1, 0, 16'd15);
    #1 rst = 1'b0;
    #1 chk_all("rs_async", 4'b0000, 4'b0000, 0, 8'h00, 0, 0, 16'd0);
    @(negedge clk);
    enable = 1'b0; bus.req_valid = 4'b0000;
    rst = 1'b1;
    drive(1, 4'b1111, 4'b1111, D0, 0); chk_all("rs_idle",    4'b0000, 4'b0000, 0, 8'h00, 0, 0, 16'd0);
    drive(1, 4'b1111, 4'b1111, D0, 0); chk_all("rs_restart", 4'b0001, 4'b0001, 1, 8'h11, 1, 0, 16'd0);
    drive(1, 4'b0000, 4'b0000, D0, 0); chk_all("rs_done",    4'b0000, 4'b0000, 0, 8'h00, 0, 0, 16'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
